input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Front-end stage between the bicycle computer pins (nMode, nTrip, nFork, nCrank) and the computer core.
- Synchronises, inverts and debounces the four active-low, open-drain inputs. Emits one-cycle press pulses, plus a trip long-press pulse.
- The core consumes only these clean pulses and levels, never raw pins.
- Default clock is 12.8 kHz (78.125 us period).

Parameters:
- SENSOR_DEBOUNCE, 8, consecutive stable cycles needed for Fork/Crank to change state (625 us); legal range 2..255.
- BUTTON_DEBOUNCE, 256, consecutive stable cycles needed for Mode/Trip to change state (20 ms); legal range 2..65535.
- LONG_PRESS, 25600, cycles Trip must stay debounced-pressed before TripLong fires (2 s); must exceed BUTTON_DEBOUNCE and be at most 65535.

Ports:
- Clock  input  1  system clock, rising-edge active.
- Reset  input  1  synchronous, active-high reset; top level derives it from nReset.
- nMode  input  1  mode button, active-low, externally pulled up.
- nTrip  input  1  trip button, active-low.
- nFork  input  1  wheel hall sensor, active-low.
- nCrank  input  1  crank hall sensor, active-low.
- ModePulse  output  1  one-cycle pulse on debounced Mode press.
- TripPulse  output  1  one-cycle pulse on debounced Trip press.
- TripLong  output  1  one-cycle pulse when Trip has been held LONG_PRESS cycles.
- ForkPulse  output  1  one-cycle pulse on debounced Fork assertion.
- CrankPulse  output  1  one-cycle pulse on debounced Crank assertion.
- Pressed  output  4  debounced active-high levels, bit order {Crank, Fork, Trip, Mode}.

Behaviour:
- Reset: all sync flops, stable states, counters, Pressed and every pulse output go to 0 (inactive) on the first Clock edge with Reset=1. Reset mid-press aborts that press. After reset, the input must debounce afresh before a pulse is produced.
- Synchroniser per channel: two flops sampling the inverted pin (s = ~nX). This gives 2 cycles of latency. A non-0/1 pin value is treated as inactive in simulation.
- Debounce FSM per channel, with states IDLE (stable=0) and ACTIVE (stable=1):
  - Counter cnt counts cycles where s != stable.
  - Any cycle with s == stable clears cnt.
  - When cnt reaches DEBOUNCE-1 while s != stable, stable toggles on that edge and cnt clears.
  - A change therefore needs DEBOUNCE consecutive differing samples; a glitch shorter than DEBOUNCE is ignored.
- Pulse: XPulse is registered and is 1 exactly in the first cycle stable is 1 after IDLE->ACTIVE. No pulse on release.
- Latency: pin falling before edge k gives Pressed/pulse high after edge k+1+DEBOUNCE, i.e. DEBOUNCE+2 cycles.
- Long press:
  - hold counter (16 bits) increments each cycle Trip stable=1 and saturates at LONG_PRESS.
  - TripLong pulses for one cycle when the counter reaches LONG_PRESS; it fires at most once per press.
  - The counter clears when Trip stable=0.
- Channels are fully independent; simultaneous activity on several channels produces simultaneous pulses.
- Counter widths: 8 bits for sensors, 16 bits for buttons; no wrap is possible within the legal ranges.
- Continuous assertion yields exactly one XPulse. Re-press is detected only after a debounced release, i.e. a return to IDLE.

Decomposition:
- Package input_pkg holds:
  - channel index constants CH_MODE=0, CH_TRIP=1, CH_FORK=2, CH_CRANK=3;
  - NUM_CH=4;
  - default debounce and long-press constants;
  - a typedef for the 16-bit counter.
- Sub-module debounce_channel (parameter DEBOUNCE, CNT_W) contains the synchroniser, debounce FSM and rising-edge pulse. It is instantiated four times.
- The long-press counter lives in input_conditioner.

Test Plan:
- Reset: hold Reset 3 cycles with all pins low -> all outputs 0; release -> no pulses for at least SENSOR_DEBOUNCE+1 cycles, then ForkPulse/CrankPulse each pulse once.
- Fork press: nFork low 25 cycles (2 ms) -> single ForkPulse exactly 10 cycles after the first low sample; Pressed[2] high for 25 cycles.
- Glitch: nCrank low 5 cycles, then high -> no CrankPulse; Pressed[3] stays 0.
- Mode button: nMode low 1280 cycles (0.1 s) -> one ModePulse at cycle 258; a 200-cycle bounce burst alternating every 3 cycles before it causes no extra pulses.
- Long trip: nTrip low 30000 cycles -> TripPulse at cycle 258; TripLong once, 25600 cycles later; nothing further until released.
- Simultaneous and reset mid-press: all four pins fall together -> all pulses coincide per their own latencies; Reset during nTrip hold at cycle 20000 -> no TripLong, and a new TripPulse comes 258 cycles after Reset drops.

Source files
------------

// File: rtl/input_pkg.sv
// Shared constants and types for the bicycle computer input conditioner.
package input_pkg;

  localparam int NUM_CH   = 4;
  localparam int CH_MODE  = 0;
  localparam int CH_TRIP  = 1;
  localparam int CH_FORK  = 2;
  localparam int CH_CRANK = 3;

  // Defaults at a 12.8 kHz clock: 625 us, 20 ms and 2 s respectively.
  localparam int DEF_SENSOR_DEBOUNCE = 8;
  localparam int DEF_BUTTON_DEBOUNCE = 256;
  localparam int DEF_LONG_PRESS      = 25600;

  localparam int SENSOR_CNT_W = 8;
  localparam int BUTTON_CNT_W = 16;

  typedef logic [15:0] hold_cnt_t;

  typedef enum logic {
    DEB_IDLE   = 1'b0,
    DEB_ACTIVE = 1'b1
  } deb_state_t;

endpackage

// File: rtl/debounce_channel.sv
// One input channel: two-flop synchroniser of the inverted pin, a
// consecutive-sample debounce FSM and a press pulse on IDLE->ACTIVE.
module debounce_channel
  import input_pkg::*;
#(
  parameter int DEBOUNCE = 8,
  parameter int CNT_W    = 8
) (
  input  logic Clock,
  input  logic Reset,
  input  logic nPin,
  output logic Pulse,
  output logic Stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             sync_p0;
  logic             sync_p1;
  deb_state_t       state;
  deb_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             pulse_nxt;
  logic             differ;

  // Synchroniser: an unknown pin level reads as inactive.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      // stage 0: sample the inverted pin
      sync_p0 <= (nPin === 1'b0);
      // stage 1: second flop, metastability settling
      sync_p1 <= sync_p0;
    end
  end

  // Debounce state, run-length counter and registered press pulse.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= DEB_IDLE;
      cnt   <= '0;
      Pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      Pulse <= pulse_nxt;
    end
  end

  // Count consecutive samples disagreeing with the stable level; toggle on
  // the DEBOUNCE-th one, and restart the count whenever the sample agrees.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    pulse_nxt = 1'b0;
    differ    = (sync_p1 != (state == DEB_ACTIVE));
    if (differ) begin
      if (cnt == CNT_LAST) begin
        state_nxt = (state == DEB_IDLE) ? DEB_ACTIVE : DEB_IDLE;
        pulse_nxt = (state == DEB_IDLE);
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  assign Stable = (state == DEB_ACTIVE);

endmodule

// File: rtl/input_conditioner.sv
// Front end between the bicycle computer pins and the core: four debounced
// channels plus a long-press detector on the Trip button.
module input_conditioner
  import input_pkg::*;
#(
  parameter int SENSOR_DEBOUNCE = DEF_SENSOR_DEBOUNCE,
  parameter int BUTTON_DEBOUNCE = DEF_BUTTON_DEBOUNCE,
  parameter int LONG_PRESS      = DEF_LONG_PRESS
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       nMode,
  input  logic       nTrip,
  input  logic       nFork,
  input  logic       nCrank,
  output logic       ModePulse,
  output logic       TripPulse,
  output logic       TripLong,
  output logic       ForkPulse,
  output logic       CrankPulse,
  output logic [3:0] Pressed
);

  localparam hold_cnt_t LONG_LAST = hold_cnt_t'(LONG_PRESS);

  logic [NUM_CH-1:0] pulse;
  logic [NUM_CH-1:0] stable;
  hold_cnt_t         hold;

  debounce_channel #(.DEBOUNCE(BUTTON_DEBOUNCE), .CNT_W(BUTTON_CNT_W)) u_mode (
    .Clock(Clock), .Reset(Reset), .nPin(nMode),
    .Pulse(pulse[CH_MODE]), .Stable(stable[CH_MODE])
  );

  debounce_channel #(.DEBOUNCE(BUTTON_DEBOUNCE), .CNT_W(BUTTON_CNT_W)) u_trip (
    .Clock(Clock), .Reset(Reset), .nPin(nTrip),
    .Pulse(pulse[CH_TRIP]), .Stable(stable[CH_TRIP])
  );

  debounce_channel #(.DEBOUNCE(SENSOR_DEBOUNCE), .CNT_W(SENSOR_CNT_W)) u_fork (
    .Clock(Clock), .Reset(Reset), .nPin(nFork),
    .Pulse(pulse[CH_FORK]), .Stable(stable[CH_FORK])
  );

  debounce_channel #(.DEBOUNCE(SENSOR_DEBOUNCE), .CNT_W(SENSOR_CNT_W)) u_crank (
    .Clock(Clock), .Reset(Reset), .nPin(nCrank),
    .Pulse(pulse[CH_CRANK]), .Stable(stable[CH_CRANK])
  );

  // Hold counter saturates at LONG_PRESS so TripLong fires once per press.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      hold     <= '0;
      TripLong <= 1'b0;
    end else if (!stable[CH_TRIP]) begin
      hold     <= '0;
      TripLong <= 1'b0;
    end else if (hold != LONG_LAST) begin
      hold     <= hold + 1'b1;
      TripLong <= (hold == (LONG_LAST - 1'b1));
    end else begin
      TripLong <= 1'b0;
    end
  end

  assign ModePulse  = pulse[CH_MODE];
  assign TripPulse  = pulse[CH_TRIP];
  assign ForkPulse  = pulse[CH_FORK];
  assign CrankPulse = pulse[CH_CRANK];
  assign Pressed    = stable;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a cycle-stamped pulse scoreboard.
module tb_input_conditioner;

  localparam logic [4:0] P_MODE  = 5'b00001;
  localparam logic [4:0] P_TRIP  = 5'b00010;
  localparam logic [4:0] P_LONG  = 5'b00100;
  localparam logic [4:0] P_FORK  = 5'b01000;
  localparam logic [4:0] P_CRANK = 5'b10000;

  typedef struct {
    int         cyc;
    logic [4:0] vec;
  } exp_t;

  logic       Clock;
  logic       Reset;
  logic       nMode, nTrip, nFork, nCrank;
  logic       ModePulse, TripPulse, TripLong, ForkPulse, CrankPulse;
  logic [3:0] Pressed;
  logic [4:0] pulses;

  int   cyc    = 0;
  int   total  = 0;
  int   passed = 0;
  int   t;
  exp_t exp_q[$];
  exp_t mon_e;

  input_conditioner dut (
    .Clock(Clock), .Reset(Reset),
    .nMode(nMode), .nTrip(nTrip), .nFork(nFork), .nCrank(nCrank),
    .ModePulse(ModePulse), .TripPulse(TripPulse), .TripLong(TripLong),
    .ForkPulse(ForkPulse), .CrankPulse(CrankPulse), .Pressed(Pressed)
  );

  assign pulses = {CrankPulse, ForkPulse, TripLong, TripPulse, ModePulse};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input int c, input logic [4:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Scoreboard: at each expected cycle compare the pulse vector, otherwise
  // any pulse at all is unexpected.
  always @(negedge Clock) begin
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mon_e = exp_q.pop_front();
      check("pulse", {27'b0, pulses}, {27'b0, mon_e.vec});
    end else if (pulses != 5'b0) begin
      check("unexpected_pulse", {27'b0, pulses}, 32'd0);
    end
  end

  initial begin
    Reset = 1'b1;
    nMode = 1'b0; nTrip = 1'b0; nFork = 1'b0; nCrank = 1'b0;
    step(3);
    check("reset_pressed", {28'b0, Pressed}, 32'd0);
    check("reset_pulses", {27'b0, pulses}, 32'd0);

    // Release reset with all pins low: sensors debounce afresh.
    Reset = 1'b0;
    t = cyc;
    push(t + 10, P_FORK | P_CRANK);
    step(9);
    check("rel_pressed_early", {28'b0, Pressed}, 32'd0);
    step(1);
    check("rel_pressed_sensors", {28'b0, Pressed}, 32'hC);
    step(10);
    nMode = 1'b1; nTrip = 1'b1; nFork = 1'b1; nCrank = 1'b1;
    step(20);
    check("idle_after_release", {28'b0, Pressed}, 32'd0);

    // Fork press of 25 cycles.
    t = cyc;
    nFork = 1'b0;
    push(t + 10, P_FORK);
    step(9);
    check("fork_before", {31'b0, Pressed[2]}, 32'd0);
    step(1);
    check("fork_on", {31'b0, Pressed[2]}, 32'd1);
    step(15);
    nFork = 1'b1;
    step(9);
    check("fork_hold_end", {31'b0, Pressed[2]}, 32'd1);
    step(1);
    check("fork_released", {31'b0, Pressed[2]}, 32'd0);

    // Crank glitch shorter than the debounce window.
    nCrank = 1'b0;
    step(5);
    nCrank = 1'b1;
    step(20);
    check("crank_glitch", {28'b0, Pressed}, 32'd0);

    // Mode bounce burst, then a steady 1280-cycle press.
    for (int i = 0; i < 200; i++) begin
      nMode = (((i / 3) % 2) == 0) ? 1'b0 : 1'b1;
      step(1);
    end
    nMode = 1'b1;
    step(3);
    check("mode_after_bounce", {31'b0, Pressed[0]}, 32'd0);
    t = cyc;
    nMode = 1'b0;
    push(t + 258, P_MODE);
    step(257);
    check("mode_before", {31'b0, Pressed[0]}, 32'd0);
    step(1);
    check("mode_on", {31'b0, Pressed[0]}, 32'd1);
    step(1280 - 258);
    nMode = 1'b1;
    step(260);
    check("mode_released", {31'b0, Pressed[0]}, 32'd0);

    // Long trip hold.
    t = cyc;
    nTrip = 1'b0;
    push(t + 258, P_TRIP);
    push(t + 258 + 25600, P_LONG);
    step(30000);
    check("trip_held", {28'b0, Pressed}, 32'h2);
    nTrip = 1'b1;
    step(260);
    check("trip_released", {28'b0, Pressed}, 32'd0);

    // All four together, then reset in the middle of the hold.
    t = cyc;
    nMode = 1'b0; nTrip = 1'b0; nFork = 1'b0; nCrank = 1'b0;
    push(t + 10, P_FORK | P_CRANK);
    push(t + 258, P_MODE | P_TRIP);
    step(10);
    check("simul_sensors", {28'b0, Pressed}, 32'hC);
    step(248);
    check("simul_all", {28'b0, Pressed}, 32'hF);
    step(20000 - 258);
    Reset = 1'b1;
    step(3);
    check("midreset_pressed", {28'b0, Pressed}, 32'd0);
    check("midreset_pulses", {27'b0, pulses}, 32'd0);
    Reset = 1'b0;
    t = cyc;
    push(t + 10, P_FORK | P_CRANK);
    push(t + 258, P_MODE | P_TRIP);
    step(300);
    check("repress_all", {28'b0, Pressed}, 32'hF);
    nMode = 1'b1; nTrip = 1'b1; nFork = 1'b1; nCrank = 1'b1;
    step(300);
    check("final_idle", {28'b0, Pressed}, 32'd0);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
